// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-side arbiter.
//   REG_ADDR_W / NUM_REGS : integer register file geometry
//   XLEN_DEF              : default register width
//   wb_req_t              : one register write (destination + value)
//   reg_onehot()          : decoded one-hot mask for a register index
package reg_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN_DEF   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (empties the FIFO, ignores i_en)
//   i_en     global enable; 0 = pointers and storage hold
//   i_push   write i_data at the tail (ignored when full)
//   i_pop    drop the head entry (ignored when empty)
//   o_head   current head entry (valid when !o_empty)
//   o_full   / o_empty   occupancy flags
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty when the index bits match.
  logic [AW:0]               wr_ptr, rd_ptr;
  logic [DEPTH-1:0][W-1:0]   mem;
  logic                      do_push, do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_head  = mem[rd_ptr[AW-1:0]];

  assign do_push = i_en && i_push && !o_full;
  assign do_pop  = i_en && i_pop  && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind a valid pointer.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered
// MDU results and tracks registers still waiting on an MDU result.
//   i_clk, i_rst_n (sync, active-low), i_clk_enable (global stall)
//   i_wb_*         pipeline writeback (highest priority, never stalled)
//   i_issue_*      MDU issue; marks destination pending
//   i_mdu_* / o_mdu_ready   MDU result stream, valid/ready handshake
//   i_chk_addr_n / o_pending_n   decode scoreboard lookups (combinational)
//   o_reg_write, o_wr_addr, o_wr_data   registered register-file write port
//   o_idle         nothing buffered and nothing pending
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clk_enable,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_mdu_valid,
  input  logic [REG_ADDR_W-1:0] i_mdu_addr,
  input  logic [XLEN-1:0]       i_mdu_data,
  output logic                  o_mdu_ready,
  input  logic [REG_ADDR_W-1:0] i_chk_addr_1,
  input  logic [REG_ADDR_W-1:0] i_chk_addr_2,
  output logic                  o_pending_1,
  output logic                  o_pending_2,
  output logic                  o_reg_write,
  output logic [REG_ADDR_W-1:0] o_wr_addr,
  output logic [XLEN-1:0]       o_wr_data,
  output logic                  o_idle
);

  localparam int EW = REG_ADDR_W + XLEN;

  logic                  wb_win;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic [NUM_REGS-1:0]   sb, sb_set, sb_clr, sb_nxt;

  // Writes to x0 are architecturally dead, so they never claim the port.
  assign wb_win = i_wb_valid && (i_wb_addr != '0);

  // x0 results complete the handshake but are dropped before the FIFO.
  assign o_mdu_ready = !fifo_full;
  assign fifo_push   = i_clk_enable && i_mdu_valid && !fifo_full && (i_mdu_addr != '0);
  assign fifo_pop    = i_clk_enable && !wb_win && !fifo_empty;

  assign head_addr = fifo_head[EW-1:XLEN];
  assign head_data = fifo_head[XLEN-1:0];

  wb_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_clk_enable),
    .i_push  (fifo_push),
    .i_data  ({i_mdu_addr, i_mdu_data}),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Scoreboard: clear on pop, then set on issue so a same-cycle re-issue wins.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (i_clk_enable && i_issue_valid && (i_issue_rd != '0)) sb_set = reg_onehot(i_issue_rd);
    if (fifo_pop) sb_clr = reg_onehot(head_addr);
    sb_nxt    = (sb & ~sb_clr) | sb_set;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sb <= '0;
    else          sb <= sb_nxt;
  end

  assign o_pending_1 = sb[i_chk_addr_1];
  assign o_pending_2 = sb[i_chk_addr_2];
  assign o_idle      = fifo_empty && (sb == '0);

  // Registered write port; address/data hold when no write is emitted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_reg_write <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
    end else if (i_clk_enable) begin
      if (wb_win) begin
        o_reg_write <= 1'b1;
        o_wr_addr   <= i_wb_addr;
        o_wr_data   <= i_wb_data;
      end else if (fifo_pop) begin
        o_reg_write <= 1'b1;
        o_wr_addr   <= head_addr;
        o_wr_data   <= head_data;
      end else begin
        o_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  localparam int FD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, wb_v, is_v, m_v, m_rdy, p1, p2, rw, idle;
  logic [4:0]  wb_a, is_rd, m_a, c1, c2, wa;
  logic [31:0] wb_d, m_d, wd;

  reg_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_enable(en),
    .i_wb_valid(wb_v), .i_wb_addr(wb_a), .i_wb_data(wb_d),
    .i_issue_valid(is_v), .i_issue_rd(is_rd),
    .i_mdu_valid(m_v), .i_mdu_addr(m_a), .i_mdu_data(m_d), .o_mdu_ready(m_rdy),
    .i_chk_addr_1(c1), .i_chk_addr_2(c2), .o_pending_1(p1), .o_pending_2(p2),
    .o_reg_write(rw), .o_wr_addr(wa), .o_wr_data(wd), .o_idle(idle)
  );

  int tests = 0, fails = 0;

  // Reference model: buffered results, pending set, last port contents.
  wb_req_t     mq[$];
  wb_req_t     expq[$];
  logic [31:0] msb;
  logic        ml_we;
  logic [4:0]  ml_a;
  logic [31:0] ml_d;
  bit          live = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic offer(input logic [4:0] a, input logic [31:0] d);
    m_v = 1'b1; m_a = a; m_d = d;
  endtask

  // One clock: check combinational outputs, advance the model, clock, clear one-shots.
  task automatic step();
    bit acc = 0;
    wb_req_t h;
    #1;
    if (live) begin
      chk("mdu_ready", 64'(m_rdy), 64'(mq.size() < FD));
      chk("idle",      64'(idle),  64'(mq.size() == 0 && msb == 0));
      chk("pending_1", 64'(p1),    64'(msb[c1]));
      chk("pending_2", 64'(p2),    64'(msb[c2]));
    end
    if (!rst_n) begin
      mq.delete(); msb = '0; ml_we = 0; ml_a = '0; ml_d = '0; live = 1;
    end else if (en && live) begin
      acc = m_v && (mq.size() < FD);
      if (wb_v && wb_a != 0) begin
        h.addr = wb_a; h.data = wb_d;
        ml_we = 1; ml_a = wb_a; ml_d = wb_d; expq.push_back(h);
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        msb[h.addr] = 1'b0;
        ml_we = 1; ml_a = h.addr; ml_d = h.data; expq.push_back(h);
      end else begin
        ml_we = 0;
      end
      if (acc && m_a != 0) begin
        h.addr = m_a; h.data = m_d; mq.push_back(h);
      end
      if (is_v && is_rd != 0) msb[is_rd] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (acc) m_v = 1'b0;
    wb_v = 1'b0;
    is_v = 1'b0;
  endtask

  // Monitor: after every edge, pop the expected write or confirm the port held.
  initial begin
    bit en_s, l;
    wb_req_t e;
    forever begin
      @(posedge clk);
      en_s = en && rst_n && live;
      l    = live;
      #2;
      if (!l) continue;
      if (en_s && rw) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_write: got addr %0d data %h expected no write", wa, wd);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", 64'(wa), 64'(e.addr));
          chk("wr_data", 64'(wd), 64'(e.data));
        end
      end else if (en_s) begin
        chk("reg_write", 64'(rw), 64'(ml_we));
        chk("hold_addr", 64'(wa), 64'(ml_a));
        chk("hold_data", 64'(wd), 64'(ml_d));
      end else begin
        chk("frozen_we",   64'(rw), 64'(ml_we));
        chk("frozen_addr", 64'(wa), 64'(ml_a));
        chk("frozen_data", 64'(wd), 64'(ml_d));
      end
    end
  end

  initial begin
    rst_n = 0; en = 1; wb_v = 0; wb_a = '0; wb_d = '0; is_v = 0; is_rd = '0;
    m_v = 0; m_a = '0; m_d = '0; c1 = '0; c2 = '0;
    @(negedge clk);
    step();
    rst_n = 1;

    // Pipeline only, then a dead x0 write
    wb_v = 1; wb_a = 5'd5; wb_d = 32'hDEADBEEF; step();
    wb_v = 1; wb_a = 5'd0; wb_d = 32'h1234;     step();
    step();

    // Contention: pipeline owns the port for 3 cycles, third MDU offer stalls
    wb_v = 1; wb_a = 5'd1; wb_d = 32'h1; offer(5'd7,  32'h11); step();
    wb_v = 1; wb_a = 5'd2; wb_d = 32'h2; offer(5'd8,  32'h22); step();
    wb_v = 1; wb_a = 5'd3; wb_d = 32'h3; offer(5'd10, 32'h33); step();
    repeat (4) step();

    // Scoreboard set/clear and set-wins on re-issue
    c1 = 5'd9; c2 = 5'd7;
    is_v = 1; is_rd = 5'd9; step();
    step();
    offer(5'd9, 32'h99); step();
    is_v = 1; is_rd = 5'd9; step();
    repeat (2) step();
    offer(5'd9, 32'h999); repeat (3) step();

    // Stall with FIFO non-empty
    wb_v = 1; wb_a = 5'd4; wb_d = 32'h4; offer(5'd11, 32'hAA); step();
    wb_v = 1; wb_a = 5'd6; wb_d = 32'h6; offer(5'd12, 32'hBB); step();
    en = 0; repeat (4) step();
    en = 1; repeat (3) step();

    // x0 MDU result: accepted, never emitted
    offer(5'd0, 32'h55); repeat (2) step();

    // Reset while results are buffered
    wb_v = 1; wb_a = 5'd13; wb_d = 32'h13; offer(5'd14, 32'hC1); step();
    wb_v = 1; wb_a = 5'd15; wb_d = 32'h15; offer(5'd16, 32'hC2); step();
    rst_n = 0; step();
    rst_n = 1; repeat (2) step();

    // Randomized traffic
    repeat (400) begin
      rst_n = ($urandom_range(0, 79) != 0);
      en    = ($urandom_range(0, 6) != 0);
      wb_v  = 1'($urandom_range(0, 1));
      wb_a  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wb_d  = $urandom;
      is_v  = ($urandom_range(0, 2) == 0);
      is_rd = 5'($urandom);
      if (!m_v && $urandom_range(0, 1) == 1) offer(5'($urandom), $urandom);
      c1 = 5'($urandom);
      c2 = 5'($urandom);
      step();
    end

    // Drain everything outstanding
    rst_n = 1; en = 1;
    repeat (8) step();
    chk("expected_drained", 64'(expq.size()), 64'd0);
    chk("mdu_offer_done",   64'(m_v),         64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
